// File: rtl/led_event_scheduler_pkg.sv
// led_event_scheduler_pkg: shared event codes, event width and display FSM states
package led_event_scheduler_pkg;
  localparam int EVT_W = 10;
  typedef enum logic [1:0] {
    EVT_IDLE      = 2'b00,
    EVT_UART_DATA = 2'b01,
    EVT_UART_ERR  = 2'b10,
    EVT_CM        = 2'b11
  } evt_type_e;
  typedef enum logic {ST_IDLE, ST_SHOW} state_e;
endpackage

// File: rtl/led_event_scheduler_if.sv
// led_event_scheduler_if: valid/ready event streams feeding the LED scheduler
interface led_event_scheduler_if;
  logic [7:0] uart_data;
  logic       uart_data_valid;
  logic       uart_data_ready;
  logic [1:0] uart_err;
  logic       uart_err_valid;
  logic       uart_err_ready;
  logic [3:0] cm_evt;
  logic       cm_evt_valid;
  logic       cm_evt_ready;
  modport master (
    output uart_data, uart_data_valid, uart_err, uart_err_valid, cm_evt, cm_evt_valid,
    input  uart_data_ready, uart_err_ready, cm_evt_ready
  );
  modport slave (
    input  uart_data, uart_data_valid, uart_err, uart_err_valid, cm_evt, cm_evt_valid,
    output uart_data_ready, uart_err_ready, cm_evt_ready
  );
endinterface

// File: rtl/led_event_scheduler_evt_fifo.sv
// evt_fifo: single-clock synchronous FIFO with exact occupancy output
module evt_fifo import led_event_scheduler_pkg::*; #(
  parameter int W     = EVT_W,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [W-1:0]               wr_data,
  input  logic                       rd_en,
  output logic [W-1:0]               rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          wr_ok, rd_ok;
  always_comb begin
    full     = level_q == (AW+1)'(DEPTH);
    empty    = level_q == '0;
    wr_ok    = wr_en && !full;
    rd_ok    = rd_en && !empty;
    wr_ptr_d = wr_ptr_q + AW'(wr_ok);
    rd_ptr_d = rd_ptr_q + AW'(rd_ok);
    level_d  = level_q + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
    rd_data  = mem_q[rd_ptr_q];
    level    = level_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
  end
endmodule

// File: rtl/led_event_scheduler.sv
// led_event_scheduler: prioritises event streams into a FIFO and holds each on the LEDs
module led_event_scheduler import led_event_scheduler_pkg::*; #(
  parameter int WIDTH_LEDS  = 16,
  parameter int HOLD_CYCLES = 25000000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  led_event_scheduler_if.slave          evt,
  input  logic [7:0]                    config_status,
  output logic [WIDTH_LEDS-1:0]         leds,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int CW = $clog2(HOLD_CYCLES) + 1;
  logic                  full, empty, wr, pop;
  logic [EVT_W-1:0]      wr_evt, rd_evt;
  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [WIDTH_LEDS-1:0] leds_q, leds_d, show_v;
  evt_fifo #(.W(EVT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .wr_en(wr), .wr_data(wr_evt), .rd_en(pop),
    .rd_data(rd_evt), .full(full), .empty(empty), .level(fifo_level)
  );
  always_comb begin
    evt.uart_err_ready  = !rst && !full && evt.uart_err_valid;
    evt.cm_evt_ready    = !rst && !full && !evt.uart_err_valid && evt.cm_evt_valid;
    evt.uart_data_ready = !rst && !full && !evt.uart_err_valid && !evt.cm_evt_valid && evt.uart_data_valid;
    wr     = evt.uart_err_ready || evt.cm_evt_ready || evt.uart_data_ready;
    wr_evt = evt.uart_err_valid ? {EVT_UART_ERR, 6'b0, evt.uart_err} :
             evt.cm_evt_valid   ? {EVT_CM, 4'b0, evt.cm_evt} : {EVT_UART_DATA, evt.uart_data};
    // cnt is always zero in IDLE, so one test covers both pop cases
    pop    = !empty && cnt_q == '0;
    show_v = '0;
    show_v[WIDTH_LEDS-1 -: 2] = rd_evt[9:8];
    show_v[7:0] = rd_evt[7:0];
    state_d = pop ? ST_SHOW : cnt_q == '0 ? ST_IDLE : state_q;
    cnt_d   = pop ? CW'(HOLD_CYCLES - 1) : cnt_q == '0 ? cnt_q : cnt_q - CW'(1);
    leds_d  = pop ? show_v : cnt_q == '0 ? WIDTH_LEDS'(config_status) : leds_q;
    leds    = leds_q;
    busy    = state_q == ST_SHOW;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      leds_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      leds_q  <= leds_d;
    end
  end
endmodule

// File: tb/tb_led_event_scheduler.sv
// tb_led_event_scheduler: directed checks of arbitration, FIFO fill, hold timing and reset
module tb_led_event_scheduler;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  config_status;
  logic [15:0] leds_a, leds_b;
  logic        busy_a, busy_b;
  logic [2:0]  lvl_a, lvl_b;
  int          n_chk = 0;
  int          n_pass = 0;
  int          sent = 0;
  int          lvl_tab [27] = '{0,1,1,2,3,4,3,4,4,4,3,3,3,3,2,2,2,2,1,1,1,1,0,0,0,0,0};
  led_event_scheduler_if ifa ();
  led_event_scheduler_if ifb ();
  always #5 clk = ~clk;
  led_event_scheduler #(.WIDTH_LEDS(16), .HOLD_CYCLES(4), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .evt(ifa), .config_status(config_status),
    .leds(leds_a), .busy(busy_a), .fifo_level(lvl_a)
  );
  led_event_scheduler #(.WIDTH_LEDS(16), .HOLD_CYCLES(1), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .evt(ifb), .config_status(config_status),
    .leds(leds_b), .busy(busy_b), .fifo_level(lvl_b)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle_src;
    ifa.uart_data = '0; ifa.uart_data_valid = 0; ifa.uart_err = '0; ifa.uart_err_valid = 0;
    ifa.cm_evt = '0; ifa.cm_evt_valid = 0;
    ifb.uart_data = '0; ifb.uart_data_valid = 0; ifb.uart_err = '0; ifb.uart_err_valid = 0;
    ifb.cm_evt = '0; ifb.cm_evt_valid = 0;
  endtask
  task automatic hold_leds(input string tag, input logic [15:0] exp, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check(tag, leds_a, exp);
    end
  endtask
  initial begin
    rst = 1; config_status = 8'hA5; idle_src();
    tick(); tick();
    ifa.uart_err_valid = 1; ifa.cm_evt_valid = 1; ifa.uart_data_valid = 1; #1;
    check("rst_err_rdy", ifa.uart_err_ready, 0);
    check("rst_cm_rdy", ifa.cm_evt_ready, 0);
    check("rst_data_rdy", ifa.uart_data_ready, 0);
    check("rst_leds", leds_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_lvl", lvl_a, 0);
    idle_src(); rst = 0;
    tick();
    check("idle_a5", leds_a, 16'h00A5);
    check("idle_busy", busy_a, 0);
    // single UART byte, HOLD_CYCLES=4
    ifa.uart_data = 8'h3C; ifa.uart_data_valid = 1; #1;
    check("data_rdy", ifa.uart_data_ready, 1);
    tick();
    ifa.uart_data_valid = 0;
    check("lvl_after_wr", lvl_a, 1);
    check("still_idle", leds_a, 16'h00A5);
    tick();
    check("show_3c", leds_a, 16'h403C);
    check("show_busy", busy_a, 1);
    check("show_lvl", lvl_a, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_3c", leds_a, 16'h403C);
      check("hold_busy", busy_a, 1);
    end
    tick();
    check("back_idle", leds_a, 16'h00A5);
    check("back_busy", busy_a, 0);
    config_status = 8'h5A;
    tick();
    check("track_cfg", leds_a, 16'h005A);
    // simultaneous sources: err > cm > data
    ifa.uart_err = 2'b10; ifa.uart_err_valid = 1;
    ifa.cm_evt = 4'h7; ifa.cm_evt_valid = 1;
    ifa.uart_data = 8'h11; ifa.uart_data_valid = 1; #1;
    check("arb_err_rdy", ifa.uart_err_ready, 1);
    check("arb_cm_wait", ifa.cm_evt_ready, 0);
    check("arb_data_wait", ifa.uart_data_ready, 0);
    tick();
    ifa.uart_err_valid = 0; #1;
    check("arb_cm_rdy", ifa.cm_evt_ready, 1);
    check("arb_data_wait2", ifa.uart_data_ready, 0);
    tick();
    ifa.cm_evt_valid = 0; #1;
    check("arb_data_rdy", ifa.uart_data_ready, 1);
    check("arb_show_err", leds_a, 16'h8002);
    tick();
    ifa.uart_data_valid = 0;
    check("arb_hold_err", leds_a, 16'h8002);
    hold_leds("arb_err", 16'h8002, 2);
    hold_leds("arb_cm", 16'hC007, 4);
    hold_leds("arb_data", 16'h4011, 4);
    hold_leds("arb_idle", 16'h005A, 1);
    // six bytes against a four-deep queue
    sent = 0;
    for (int k = 0; k < 27; k++) begin
      int b;
      b = (k - 2) / 4;
      ifa.uart_data = 8'hA0 + 8'(sent); ifa.uart_data_valid = sent < 6; #1;
      check("fill_rdy", ifa.uart_data_ready, (k <= 6 && k != 5));
      check("fill_lvl", lvl_a, lvl_tab[k]);
      check("fill_leds", leds_a, (k <= 1 || k == 26) ? 16'h005A : {8'h40, 8'hA0 + 8'(b)});
      if (ifa.uart_data_ready && ifa.uart_data_valid) sent++;
      tick();
    end
    ifa.uart_data_valid = 0;
    check("fill_sent", sent, 6);
    // reset while holding with three events queued
    for (int i = 0; i < 4; i++) begin
      ifa.uart_data = 8'(i + 1); ifa.uart_data_valid = 1; #1;
      check("rq_rdy", ifa.uart_data_ready, 1);
      tick();
    end
    ifa.uart_data_valid = 0;
    check("rq_lvl", lvl_a, 3);
    check("rq_leds", leds_a, 16'h4001);
    check("rq_busy", busy_a, 1);
    rst = 1;
    tick();
    check("mid_rst_leds", leds_a, 0);
    check("mid_rst_lvl", lvl_a, 0);
    check("mid_rst_busy", busy_a, 0);
    rst = 0;
    tick();
    check("post_rst_idle", leds_a, 16'h005A);
    hold_leds("no_replay", 16'h005A, 20);
    check("no_replay_busy", busy_a, 0);
    // HOLD_CYCLES=1 back-to-back stream
    ifb.cm_evt = 4'h1; ifb.cm_evt_valid = 1; #1;
    check("h1_rdy1", ifb.cm_evt_ready, 1);
    tick();
    ifb.cm_evt = 4'h2; #1;
    check("h1_rdy2", ifb.cm_evt_ready, 1);
    check("h1_idle", leds_b, 16'h005A);
    tick();
    ifb.cm_evt = 4'h3; #1;
    check("h1_rdy3", ifb.cm_evt_ready, 1);
    check("h1_c001", leds_b, 16'hC001);
    tick();
    ifb.cm_evt_valid = 0;
    check("h1_c002", leds_b, 16'hC002);
    check("h1_busy", busy_b, 1);
    tick();
    check("h1_c003", leds_b, 16'hC003);
    tick();
    check("h1_back_idle", leds_b, 16'h005A);
    check("h1_busy_off", busy_b, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
